conv55_column_feeder: RTL and testbench

Streaming window-column generator that sits directly upstream of the 5x5 PIM convolution stage. It accepts a raster-order pixel stream (one pixel per channel per beat) and buffers KERNEL_SIZE-1 image rows per channel. Once enough rows are buffered, it emits one vertical KERNEL_SIZE-pixel column per channel per accepted beat, together with a single-cycle `en` latch strobe. It also flags when the downstream column register holds a complete KERNEL_SIZE x KERNEL_SIZE window, and marks the end of each frame.

---
 rtl/conv55_column_feeder.sv | 138 +++++++++++++
 tb/tb_conv55_column_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv55_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv55_column_feeder
// Description : Streaming window-column generator for a KxK convolution stage.
//               Buffers KERNEL_SIZE-1 image rows per channel and, once enough
//               rows are held, emits one vertical KERNEL_SIZE-pixel column per
//               channel for every accepted beat, with an en latch strobe,
//               full-window flag, position indices and end-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
module conv55_column_feeder #(
  parameter int BIT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNEL     = 4,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [BIT_WIDTH*CHANNEL-1:0]              pixel_in,
  input  logic                                      hold,
  output logic                                      en,
  output logic [BIT_WIDTH*KERNEL_SIZE*CHANNEL-1:0]  column_out,
  output logic                                      window_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0]             row_idx,
  output logic [$clog2(IMG_WIDTH)-1:0]              col_idx,
  output logic                                      frame_done
);

  localparam int ROW_W    = $clog2(IMG_HEIGHT);
  localparam int COL_W    = $clog2(IMG_WIDTH);
  localparam int COL_BITS = BIT_WIDTH * KERNEL_SIZE;
  localparam int OUT_W    = COL_BITS * CHANNEL;

  localparam logic [0:0] S_FILL   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [ROW_W-1:0] c_ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] c_ROW_FILL_LAST = ROW_W'(KERNEL_SIZE - 2);
  localparam logic [COL_W-1:0] c_COL_LAST      = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] c_COL_WINDOW    = COL_W'(KERNEL_SIZE - 1);

  logic [0:0]       r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_stream_beat;
  logic [OUT_W-1:0] w_column;

  // Ready is purely a function of stall and reset, never of in_valid.
  assign in_ready      = !hold && !rst;
  assign w_accept      = in_valid && in_ready;
  assign w_col_last    = (r_col == c_COL_LAST);
  assign w_row_last    = (r_row == c_ROW_LAST);
  assign w_stream_beat = w_accept && (r_state == S_STREAM);

  // Per-channel line buffers and column assembly. Slot 0 holds the oldest
  // row; the live pixel occupies the top slot without being stored first.
  for (genvar gi = 0; gi < CHANNEL; gi++) begin : g_ch
    logic [BIT_WIDTH-1:0] r_lb [KERNEL_SIZE-1][IMG_WIDTH];

    for (genvar gk = 0; gk < KERNEL_SIZE - 1; gk++) begin : g_slot
      assign w_column[gi*COL_BITS + gk*BIT_WIDTH +: BIT_WIDTH] = r_lb[gk][r_col];
    end

    assign w_column[gi*COL_BITS + (KERNEL_SIZE-1)*BIT_WIDTH +: BIT_WIDTH] =
      pixel_in[gi*BIT_WIDTH +: BIT_WIDTH];

    // Shift the column's history up one row and store the new pixel at the
    // bottom; contents need no reset because FILL writes every slot first.
    always_ff @(posedge clk) begin
      if (w_accept) begin
        for (int j = 0; j < KERNEL_SIZE - 2; j++) begin
          r_lb[j][r_col] <= r_lb[j+1][r_col];
        end
        r_lb[KERNEL_SIZE-2][r_col] <= pixel_in[gi*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Raster position counters and FILL/STREAM sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_state <= S_FILL;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end

      case (r_state)
        S_FILL: begin
          if (w_col_last && (r_row == c_ROW_FILL_LAST)) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_col_last && w_row_last) begin
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Registered output stage: strobes pulse per STREAM beat, data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en           <= 1'b0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      column_out   <= '0;
      row_idx      <= '0;
      col_idx      <= '0;
    end else begin
      en           <= w_stream_beat;
      window_valid <= w_stream_beat && (r_col >= c_COL_WINDOW);
      frame_done   <= w_stream_beat && w_row_last && w_col_last;
      if (w_stream_beat) begin
        column_out <= w_column;
        row_idx    <= r_row;
        col_idx    <= r_col;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv55_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv55_column_feeder
// Description : Self-checking bench for conv55_column_feeder on an 8x8 image.
//               Expected columns are queued as beats are driven and compared
//               whenever the design raises en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv55_column_feeder;

  localparam int BW    = 8;
  localparam int K     = 5;
  localparam int CH    = 4;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int OUT_W = BW * K * CH;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BW*CH-1:0]  pixel_in;
  logic              hold;
  logic              en;
  logic [OUT_W-1:0]  column_out;
  logic              window_valid;
  logic [2:0]        row_idx;
  logic [2:0]        col_idx;
  logic              frame_done;

  conv55_column_feeder #(
    .BIT_WIDTH   (BW),
    .KERNEL_SIZE (K),
    .CHANNEL     (CH),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pixel_in     (pixel_in),
    .hold         (hold),
    .en           (en),
    .column_out   (column_out),
    .window_valid (window_valid),
    .row_idx      (row_idx),
    .col_idx      (col_idx),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] col;
    logic [2:0]       r;
    logic [2:0]       c;
    logic             wv;
    logic             fd;
  } exp_t;

  exp_t sb[$];

  int n_checks  = 0;
  int n_errors  = 0;
  int en_count  = 0;
  int fd_count  = 0;
  int cyc       = 0;
  int m_row     = 0;
  int m_col     = 0;

  function automatic logic [BW*CH-1:0] pix_beat(int r, int c);
    logic [BW*CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i*BW +: BW] = 8'(r*8 + c + i);
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] exp_column(int r, int c);
    logic [OUT_W-1:0] v;
    for (int i = 0; i < CH; i++)
      for (int k = 0; k < K; k++)
        v[i*BW*K + k*BW +: BW] = 8'((r - (K-1) + k)*8 + c + i);
    return v;
  endfunction

  function automatic logic [BW*K-1:0] ch_slice(logic [OUT_W-1:0] v, int ch);
    return v[ch*BW*K +: BW*K];
  endfunction

  // Scoreboard consumer: every en must match the oldest queued expectation.
  always @(negedge clk) begin
    cyc++;
    if (en === 1'b1) begin
      exp_t e;
      en_count++;
      if (frame_done === 1'b1) fd_count++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_en: got en=1 at row=%0d col=%0d, required no en", row_idx, col_idx);
      end else begin
        e = sb.pop_front();
        if (column_out !== e.col) begin
          n_errors++;
          $display("FAIL sb_column: got %h, required %h", column_out, e.col);
        end
        n_checks++;
        if (row_idx !== e.r || col_idx !== e.c) begin
          n_errors++;
          $display("FAIL sb_index: got (%0d,%0d), required (%0d,%0d)", row_idx, col_idx, e.r, e.c);
        end
        n_checks++;
        if (window_valid !== e.wv) begin
          n_errors++;
          $display("FAIL sb_window_valid: got %b, required %b", window_valid, e.wv);
        end
        n_checks++;
        if (frame_done !== e.fd) begin
          n_errors++;
          $display("FAIL sb_frame_done: got %b, required %b", frame_done, e.fd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  // One accepted beat at the model position; queues its expected column.
  task automatic send_beat();
    exp_t e;
    @(negedge clk);
    hold     = 1'b0;
    in_valid = 1'b1;
    pixel_in = pix_beat(m_row, m_col);
    @(posedge clk);
    if (m_row >= K-1) begin
      e.col = exp_column(m_row, m_col);
      e.r   = 3'(m_row);
      e.c   = 3'(m_col);
      e.wv  = (m_col >= K-1);
      e.fd  = (m_row == H-1) && (m_col == W-1);
      sb.push_back(e);
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    hold     = 1'b0;
    in_valid = 1'b1;
    pixel_in = pix_beat(0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    n_checks++;
    if (en !== 1'b0 || window_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_strobes: got en=%b wv=%b fd=%b, required 0", en, window_valid, frame_done);
    end
    n_checks++;
    if (column_out !== '0) begin n_errors++; $display("FAIL reset_column: got %h, required 0", column_out); end
    n_checks++;
    if (row_idx !== 3'd0 || col_idx !== 3'd0) begin
      n_errors++; $display("FAIL reset_index: got (%0d,%0d), required (0,0)", row_idx, col_idx);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_fill_first_column();
    repeat (32) send_beat();
    n_checks++;
    if (en_count != 0 || en !== 1'b0) begin
      n_errors++; $display("FAIL fill_no_en: got %0d en pulses, required 0", en_count);
    end
    send_beat();
    n_checks++;
    if (en !== 1'b1 || row_idx !== 3'd4 || col_idx !== 3'd0 || window_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL first_column_flags: got en=%b (%0d,%0d) wv=%b, required en=1 (4,0) wv=0",
               en, row_idx, col_idx, window_valid);
    end
    n_checks++;
    if (ch_slice(column_out, 0) !== {8'd32, 8'd24, 8'd16, 8'd8, 8'd0}) begin
      n_errors++; $display("FAIL first_column_ch0: got %h, required 2018100800", ch_slice(column_out, 0));
    end
    n_checks++;
    if (ch_slice(column_out, 3) !== {8'd35, 8'd27, 8'd19, 8'd11, 8'd3}) begin
      n_errors++; $display("FAIL first_column_ch3: got %h, required 231b130b03", ch_slice(column_out, 3));
    end
  endtask

  task automatic test_first_window();
    int c0;
    int e0;
    repeat (4) send_beat();
    n_checks++;
    if (window_valid !== 1'b1 || col_idx !== 3'd4) begin
      n_errors++; $display("FAIL first_window_flag: got wv=%b col=%0d, required wv=1 col=4", window_valid, col_idx);
    end
    n_checks++;
    if (ch_slice(column_out, 0) !== {8'd36, 8'd28, 8'd20, 8'd12, 8'd4}) begin
      n_errors++; $display("FAIL first_window_ch0: got %h, required 241c140c04", ch_slice(column_out, 0));
    end
    c0 = cyc;
    e0 = en_count;
    repeat (6) send_beat();
    @(negedge clk);
    #1;
    n_checks++;
    if ((en_count - e0) != (cyc - c0)) begin
      n_errors++; $display("FAIL en_continuous: got %0d en over %0d cycles, required equal", en_count - e0, cyc - c0);
    end
  endtask

  task automatic test_hold();
    int held_c;
    held_c = m_col;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      hold     = 1'b1;
      in_valid = 1'b1;
      pixel_in = pix_beat(m_row, m_col);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL hold_in_ready: got %b, required 0", in_ready); end
      @(posedge clk);
      #1;
      n_checks++;
      if (en !== 1'b0) begin n_errors++; $display("FAIL hold_en: got %b, required 0", en); end
    end
    send_beat();
    n_checks++;
    if (en !== 1'b1 || row_idx !== 3'd5 || col_idx !== 3'(held_c)) begin
      n_errors++; $display("FAIL hold_resume: got en=%b (%0d,%0d), required en=1 (5,%0d)", en, row_idx, col_idx, held_c);
    end
    send_beat();
    n_checks++;
    if (col_idx !== 3'(held_c + 1)) begin
      n_errors++; $display("FAIL hold_next_col: got %0d, required %0d", col_idx, held_c + 1);
    end
  endtask

  task automatic test_frame_boundary();
    int fd0;
    int e0;
    fd0 = fd_count;
    repeat (W*H - (m_row*W + m_col)) send_beat();
    n_checks++;
    if (frame_done !== 1'b1 || row_idx !== 3'd7 || col_idx !== 3'd7) begin
      n_errors++; $display("FAIL frame_done_1: got fd=%b (%0d,%0d), required fd=1 (7,7)", frame_done, row_idx, col_idx);
    end
    n_checks++;
    if (ch_slice(column_out, 0) !== {8'd63, 8'd55, 8'd47, 8'd39, 8'd31}) begin
      n_errors++; $display("FAIL frame_last_ch0: got %h, required 3f372f271f", ch_slice(column_out, 0));
    end
    @(negedge clk);
    #1;
    e0 = en_count;
    repeat (32) send_beat();
    n_checks++;
    if (en_count != e0 || en !== 1'b0) begin
      n_errors++; $display("FAIL frame2_fill: got %0d en pulses, required 0", en_count - e0);
    end
    send_beat();
    n_checks++;
    if (en !== 1'b1 || row_idx !== 3'd4 || col_idx !== 3'd0 ||
        ch_slice(column_out, 0) !== {8'd32, 8'd24, 8'd16, 8'd8, 8'd0}) begin
      n_errors++; $display("FAIL frame2_first: got en=%b (%0d,%0d) ch0=%h, required en=1 (4,0) ch0=2018100800",
                           en, row_idx, col_idx, ch_slice(column_out, 0));
    end
    repeat (W*H - (m_row*W + m_col)) send_beat();
    n_checks++;
    if (frame_done !== 1'b1) begin n_errors++; $display("FAIL frame_done_2: got %b, required 1", frame_done); end
    @(negedge clk);
    #1;
    n_checks++;
    if (fd_count - fd0 != 2) begin
      n_errors++; $display("FAIL frame_done_count: got %0d, required 2", fd_count - fd0);
    end
  endtask

  task automatic test_async_reset();
    int e0;
    repeat (6*W + 3) send_beat();
    @(negedge clk);
    in_valid = 1'b1;
    pixel_in = pix_beat(m_row, m_col);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (en !== 1'b0 || window_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL async_strobes: got en=%b wv=%b fd=%b rdy=%b, required 0",
                           en, window_valid, frame_done, in_ready);
    end
    n_checks++;
    if (column_out !== '0 || row_idx !== 3'd0 || col_idx !== 3'd0) begin
      n_errors++; $display("FAIL async_data: got col=%h (%0d,%0d), required 0 (0,0)", column_out, row_idx, col_idx);
    end
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    m_row    = 0;
    m_col    = 0;
    e0       = en_count;
    repeat (32) send_beat();
    n_checks++;
    if (en_count != e0) begin
      n_errors++; $display("FAIL post_reset_fill: got %0d en pulses, required 0", en_count - e0);
    end
    send_beat();
    n_checks++;
    if (en !== 1'b1 || row_idx !== 3'd4 || col_idx !== 3'd0 ||
        ch_slice(column_out, 3) !== {8'd35, 8'd27, 8'd19, 8'd11, 8'd3}) begin
      n_errors++; $display("FAIL post_reset_first: got en=%b (%0d,%0d) ch3=%h, required en=1 (4,0) ch3=231b130b03",
                           en, row_idx, col_idx, ch_slice(column_out, 3));
    end
  endtask

  initial begin
    test_reset();
    test_fill_first_column();
    test_first_window();
    test_hold();
    test_frame_boundary();
    test_async_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_drain: got %0d pending columns, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
